// File: rtl/drum_note_recorder_pkg.sv
// -----------------------------------------------------------------------------
// drum_note_recorder_pkg
//   Shared definitions for the drum note memory format. Both the recorder
//   (writer) and the playback path (reader) import this package.
//
//   Event word layout: {delta[TS_W-1:0], note[NOTE_W-1:0]}
//     note 0..3 = drum pad, NOTE_END = end-of-take marker.
// -----------------------------------------------------------------------------
package drum_note_recorder_pkg;

    localparam int NOTE_W    = 3;   // width of the note field in an event word
    localparam int DRUM_KEYS = 4;   // number of drum pads (F, G, H, J)

    localparam logic [NOTE_W-1:0] DRUM_TOPLEFT = 3'd0;
    localparam logic [NOTE_W-1:0] DRUM_BASS    = 3'd1;
    localparam logic [NOTE_W-1:0] DRUM_MIDDLE  = 3'd2;
    localparam logic [NOTE_W-1:0] DRUM_CYMBAL  = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_END     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REC,
        ST_FLUSH,
        ST_END
    } rec_state_t;

    // Lowest set pad in a press mask, as a note code. An empty mask yields
    // DRUM_CYMBAL, so callers must qualify the result with mask != 0.
    function automatic logic [NOTE_W-1:0] lowest_note(input logic [DRUM_KEYS-1:0] mask);
        if (mask[0])      return DRUM_TOPLEFT;
        else if (mask[1]) return DRUM_BASS;
        else if (mask[2]) return DRUM_MIDDLE;
        else              return DRUM_CYMBAL;
    endfunction

endpackage

// File: rtl/drum_note_recorder_tick.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides clk down to the timestamp tick. Counts 0 .. TICK_DIV-1 and
//   asserts tick for the one cycle in which the count wraps.
//
//   Ports:
//     clk    - system clock
//     resetn - synchronous active-low reset
//     clear  - restart the count from 0 (no tick in that cycle)
//     tick   - one-cycle pulse every TICK_DIV cycles
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 500_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: reset is synchronous here, so it lives inside the clocked branch
    // and is only seen on a rising clk edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/drum_note_recorder.sv
// -----------------------------------------------------------------------------
// drum_note_recorder
//   Records drum-pad presses during a take as time-stamped note events in the
//   drum note memory, one event per word, closed by an end marker.
//
//   Ports:
//     clk, resetn     - clock, synchronous active-low reset
//     recordEnable    - high while the system is in its record state
//     drumKeys[3:0]   - pad levels, bit0=F .. bit3=J (notes 0..3)
//     memWriteEnable  - one-cycle write strobe
//     memAddress      - write address
//     memWriteData    - {delta, note}
//     eventCount      - events written in the current take (marker excluded)
//     full            - note slots exhausted, further presses dropped
//     recordDone      - one-cycle pulse with the end-marker write
// -----------------------------------------------------------------------------
module drum_note_recorder
    import drum_note_recorder_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TS_W     = 16,
    parameter int TICK_DIV = 500_000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     recordEnable,
    input  logic [DRUM_KEYS-1:0]     drumKeys,
    output logic                     memWriteEnable,
    output logic [ADDR_W-1:0]        memAddress,
    output logic [TS_W+NOTE_W-1:0]   memWriteData,
    output logic [ADDR_W-1:0]        eventCount,
    output logic                     full,
    output logic                     recordDone
);

    // The top address is reserved for the end marker.
    localparam logic [ADDR_W-1:0] LAST_SLOT = '1;
    localparam logic [TS_W-1:0]   DELTA_MAX = '1;

    rec_state_t           state, state_next;
    logic [DRUM_KEYS-1:0] key_prev;
    logic [DRUM_KEYS-1:0] pending;
    logic [DRUM_KEYS-1:0] pending_next;
    logic [DRUM_KEYS-1:0] rise;
    logic [DRUM_KEYS-1:0] req;
    logic [DRUM_KEYS-1:0] svc_mask;
    logic [NOTE_W-1:0]    svc_note;
    logic [TS_W-1:0]      delta_cnt;
    logic [ADDR_W-1:0]    addr;
    logic                 do_write;
    logic                 start_take;
    logic                 tick;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clear  (start_take),
        .tick   (tick)
    );

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        rise         = drumKeys & ~key_prev;
        req          = pending;
        do_write     = 1'b0;
        pending_next = '0;
        start_take   = (state == ST_IDLE) && recordEnable;
        state_next   = state;

        // New presses only join the queue while the take is live.
        if (state == ST_REC) begin
            req = pending | rise;
        end

        svc_note = lowest_note(req);
        svc_mask = 4'b0001 << svc_note;

        // Once full, whatever is queued is dropped instead of serviced.
        if ((state == ST_REC || state == ST_FLUSH) && !full) begin
            pending_next = req & ~svc_mask;
            do_write     = (req != '0);
        end

        case (state)
            ST_IDLE:  if (recordEnable) state_next = ST_REC;
            // Decided on the mask after this cycle's service, so a press
            // landing in the same cycle as the stop is still flushed.
            ST_REC:   if (!recordEnable)
                          state_next = (pending_next != '0) ? ST_FLUSH : ST_END;
            ST_FLUSH: if (pending_next == '0) state_next = ST_END;
            ST_END:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_prev       <= '0;
            pending        <= '0;
            delta_cnt      <= '0;
            addr           <= '0;
            eventCount     <= '0;
            full           <= 1'b0;
            memWriteEnable <= 1'b0;
            memAddress     <= '0;
            memWriteData   <= '0;
            recordDone     <= 1'b0;
        end else begin
            memWriteEnable <= 1'b0;
            recordDone     <= 1'b0;

            if (start_take) begin
                addr       <= '0;
                eventCount <= '0;
                full       <= 1'b0;
                pending    <= '0;
                delta_cnt  <= '0;
                // Pads already held at entry must not count as presses.
                key_prev   <= drumKeys;
            end

            if (state == ST_REC) begin
                key_prev <= drumKeys;
            end

            if (state == ST_REC || state == ST_FLUSH) begin
                pending <= pending_next;
                if (do_write) begin
                    memWriteEnable <= 1'b1;
                    memAddress     <= addr;
                    memWriteData   <= {delta_cnt, svc_note};
                    addr           <= addr + ADDR_W'(1);
                    eventCount     <= eventCount + ADDR_W'(1);
                    if (eventCount + ADDR_W'(1) == LAST_SLOT) full <= 1'b1;
                    // A tick in the write cycle belongs to the next interval.
                    delta_cnt      <= tick ? TS_W'(1) : '0;
                end else if (tick && delta_cnt != DELTA_MAX) begin
                    delta_cnt <= delta_cnt + TS_W'(1);
                end
            end

            if (state == ST_END) begin
                memWriteEnable <= 1'b1;
                memAddress     <= addr;
                memWriteData   <= {delta_cnt, NOTE_END};
                recordDone     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drum_note_recorder.sv
// -----------------------------------------------------------------------------
// tb_drum_note_recorder
//   Self-checking bench for drum_note_recorder (ADDR_W=3, TS_W=4, TICK_DIV=4).
//   A behavioural model predicts every output after every clock edge; a
//   vector table and directed sequences add hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_drum_note_recorder;

    localparam int ADDR_W   = 3;
    localparam int TS_W     = 4;
    localparam int TICK_DIV = 4;
    localparam int DW       = TS_W + 3;
    localparam int CAP      = 1 << ADDR_W;
    localparam int MAXD     = (1 << TS_W) - 1;

    logic              clk = 1'b0;
    logic              resetn;
    logic              rec_en;
    logic [3:0]        keys;
    logic              memWriteEnable;
    logic [ADDR_W-1:0] memAddress;
    logic [DW-1:0]     memWriteData;
    logic [ADDR_W-1:0] eventCount;
    logic              full;
    logic              recordDone;

    drum_note_recorder #(
        .ADDR_W   (ADDR_W),
        .TS_W     (TS_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .recordEnable   (rec_en),
        .drumKeys       (keys),
        .memWriteEnable (memWriteEnable),
        .memAddress     (memAddress),
        .memWriteData   (memWriteData),
        .eventCount     (eventCount),
        .full           (full),
        .recordDone     (recordDone)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A take is described by: the edge it started on, the set of pads waiting
    // to be written, how many events are stored, and the tick count at the
    // last write. Ticks fall on edges entry+k*TICK_DIV, k>=1.
    bit   m_active, m_stopping, m_marker_due, m_full;
    int   m_entry, m_ref, m_count;
    int   pend_q[$];
    logic [3:0] m_prev;
    logic e_we, e_done, e_full;
    int   e_addr, e_data, e_count;

    function automatic int ticks_before(int t);
        return (t - m_entry - 1) / TICK_DIV;
    endfunction

    function automatic int delta_now();
        int d = ticks_before(cyc) - m_ref;
        return (d > MAXD) ? MAXD : d;
    endfunction

    task automatic model_edge();
        if (!resetn) begin
            m_active = 0; m_stopping = 0; m_marker_due = 0; m_full = 0;
            m_count = 0; m_ref = 0; m_prev = '0;
            pend_q.delete();
            e_we = 0; e_done = 0; e_full = 0; e_addr = 0; e_data = 0; e_count = 0;
        end else begin
            e_we = 0; e_done = 0;
            if (m_marker_due) begin
                e_we = 1; e_done = 1;
                e_addr = m_count;
                e_data = delta_now() * 8 + 7;
                m_marker_due = 0; m_active = 0;
            end else if (m_active) begin
                if (!m_stopping) begin
                    for (int k = 0; k < 4; k++) begin
                        if (keys[k] && !m_prev[k]) begin
                            bit seen = 0;
                            foreach (pend_q[j]) if (pend_q[j] == k) seen = 1;
                            if (!seen) pend_q.push_back(k);
                        end
                    end
                    m_prev = keys;
                end
                if (m_full) begin
                    pend_q.delete();
                end else if (pend_q.size() > 0) begin
                    int mi = 0;
                    foreach (pend_q[j]) if (pend_q[j] < pend_q[mi]) mi = j;
                    e_we = 1;
                    e_addr = m_count;
                    e_data = delta_now() * 8 + pend_q[mi];
                    pend_q.delete(mi);
                    m_ref = ticks_before(cyc);
                    m_count++;
                    if (m_count == CAP - 1) m_full = 1;
                    e_count = m_count;
                    e_full = m_full;
                end
                if (!m_stopping && !rec_en) m_stopping = 1;
                if (m_stopping && pend_q.size() == 0) m_marker_due = 1;
            end else if (rec_en) begin
                m_active = 1; m_stopping = 0; m_full = 0;
                m_entry = cyc; m_ref = 0; m_count = 0;
                m_prev = keys;
                pend_q.delete();
                e_count = 0; e_full = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("we",    memWriteEnable, e_we);
        check("addr",  memAddress,     e_addr);
        check("data",  memWriteData,   e_data);
        check("done",  recordDone,     e_done);
        check("count", eventCount,     e_count);
        check("full",  full,           e_full);
    endtask

    // One clock: model consumes the current inputs, DUT sees the same edge,
    // outputs are compared at the following falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rstn;
        logic       rec;
        logic [3:0] k;
        logic       we;
        int         addr;
        int         data;
        logic       done;
        int         cnt;
        logic       fl;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    initial begin
        resetn = 1'b0; rec_en = 1'b0; keys = '0;

        // Pre-held G at entry, G re-press, F/H/J together, stop during a
        // F+G press, flush and marker.
        vecs[0]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 0, 0, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 0, 0, 1'b0, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'b0010, 1'b0, 0, 0, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'b0010, 1'b0, 0, 0, 1'b0, 0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 0, 0, 1'b0, 0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 4'b0010, 1'b1, 0, 1, 1'b0, 1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 4'b0010, 1'b0, 0, 1, 1'b0, 1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 4'b1101, 1'b1, 1, 8, 1'b0, 2, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4'b1101, 1'b1, 2, 2, 1'b0, 3, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 4'b1101, 1'b1, 3, 3, 1'b0, 4, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'b0000, 1'b0, 3, 3, 1'b0, 4, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'b0011, 1'b1, 4, 8, 1'b0, 5, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 4'b0011, 1'b1, 5, 1, 1'b0, 6, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 4'b0000, 1'b1, 6, 7, 1'b1, 6, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 4'b0000, 1'b0, 6, 7, 1'b0, 6, 1'b0};

        for (int i = 0; i < NV; i++) begin
            resetn = vecs[i].rstn;
            rec_en = vecs[i].rec;
            keys   = vecs[i].k;
            step();
            check($sformatf("vec%0d_we", i),    memWriteEnable, vecs[i].we);
            check($sformatf("vec%0d_addr", i),  memAddress,     vecs[i].addr);
            check($sformatf("vec%0d_data", i),  memWriteData,   vecs[i].data);
            check($sformatf("vec%0d_done", i),  recordDone,     vecs[i].done);
            check($sformatf("vec%0d_count", i), eventCount,     vecs[i].cnt);
            check($sformatf("vec%0d_full", i),  full,           vecs[i].fl);
        end

        // ---- single press after 10 ticks ----
        rec_en = 1'b1; keys = '0;
        step();
        repeat (40) step();
        keys = 4'b0001;
        step();
        check("single_we",    memWriteEnable, 1);
        check("single_addr",  memAddress,     0);
        check("single_data",  memWriteData,   10 * 8 + 0);
        check("single_count", eventCount,     1);
        keys = '0; rec_en = 1'b0;
        step();
        check("single_no_extra", memWriteEnable, 0);
        step();
        check("single_marker_done", recordDone,   1);
        check("single_marker_addr", memAddress,   1);
        check("single_marker_data", memWriteData, 7);
        step();
        check("single_done_once", recordDone, 0);

        // ---- overflow: 9 presses into 7 slots ----
        rec_en = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            keys = 4'b0001;
            step();
            if (i < 7) begin
                check($sformatf("ovf_we%0d", i),   memWriteEnable, 1);
                check($sformatf("ovf_addr%0d", i), memAddress,     i);
            end else begin
                check($sformatf("ovf_drop%0d", i), memWriteEnable, 0);
            end
            if (i == 6) begin
                check("ovf_full",  full,       1);
                check("ovf_count", eventCount, 7);
            end
            keys = 4'b0000;
            step();
        end
        rec_en = 1'b0;
        step();
        step();
        check("ovf_marker_we",   memWriteEnable,    1);
        check("ovf_marker_addr", memAddress,        7);
        check("ovf_marker_note", memWriteData[2:0], 7);
        check("ovf_marker_done", recordDone,        1);
        step();
        check("ovf_count_hold", eventCount, 7);
        check("ovf_full_hold",  full,       1);

        // ---- delta saturation, then reset mid-take ----
        rec_en = 1'b1;
        step();
        repeat (80) step();
        keys = 4'b0001;
        step();
        check("sat_we",   memWriteEnable, 1);
        check("sat_data", memWriteData,   MAXD * 8 + 0);
        keys = '0;
        step();
        resetn = 1'b0; rec_en = 1'b0;
        step();
        check("rst_we",    memWriteEnable, 0);
        check("rst_addr",  memAddress,     0);
        check("rst_data",  memWriteData,   0);
        check("rst_done",  recordDone,     0);
        check("rst_count", eventCount,     0);
        check("rst_full",  full,           0);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_no_marker%0d", i), memWriteEnable | recordDone, 0);
        end

        // ---- randomized takes against the model ----
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 99) < 3) rec_en = ~rec_en;
                for (int k = 0; k < 4; k++) begin
                    if ((ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0))
                        keys[k] = ~keys[k];
                end
                resetn = ($urandom_range(0, 599) != 0);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drum_note_recorder.md
# drum_note_recorder

Captures live drum-pad presses (keys F, G, H, J) while the system is in its record state and writes them as time-stamped note events into the drum note memory. The drum playback path reads the same memory and decodes the 3-bit note field. This block is the writer side of that memory format: one event per word, terminated by an end marker.

## Interface
Parameters:
- `ADDR_W`, 8: note memory address width; capacity is 2^ADDR_W words.
- `TS_W`, 16: width of the delta-time field.
- `TICK_DIV`, 500_000: clk cycles per timestamp tick (10 ms at 50 MHz); must be ≥ 2.

Ports:
- `clk`, in, 1: system clock; all logic on posedge.
- `resetn`, in, 1: reset, synchronous, active-low.
- `recordEnable`, in, 1: level input, high while the top-level state is the record state.
- `drumKeys`, in, 4: key levels; bit0=F (note 0), bit1=G (1), bit2=H (2), bit3=J (3).
- `memWriteEnable`, out, 1: one-cycle write strobe.
- `memAddress`, out, ADDR_W: write address.
- `memWriteData`, out, TS_W+3: `{delta[TS_W-1:0], note[2:0]}`; note 0–3 is a drum, 3'b111 is the end marker.
- `eventCount`, out, ADDR_W: number of note events written in the current take (marker excluded).
- `full`, out, 1: note slots exhausted; further presses are dropped.
- `recordDone`, out, 1: one-cycle pulse when the end marker is written.

## Operation
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - `keyPrev`, `pending`, the prescaler and `deltaCnt` are all 0.
- FSM states: IDLE, REC, FLUSH, END.
  - IDLE → REC on `recordEnable`=1. On entry, clear the address, `eventCount`, `full`, `pending`, the prescaler and `deltaCnt`. Load `keyPrev` with the current `drumKeys`, so keys already held do not register as presses.
  - REC → FLUSH on `recordEnable`=0 when `pending`≠0.
  - REC → END on `recordEnable`=0 when `pending`=0.
  - FLUSH → END once `pending`=0.
  - END writes the marker, then goes to IDLE.
  - A `recordEnable` level change during FLUSH or END is ignored. A new take needs IDLE first.
- Edge detection: `rise = drumKeys & ~keyPrev`. `keyPrev <= drumKeys` every cycle in REC.
- `pending` is a 4-bit mask.
  - Each cycle in REC: `pending_next = (pending | rise)` with the serviced bit removed.
  - The serviced bit is the lowest set bit of `pending | rise`.
  - Exactly one event is written per cycle.
  - Simultaneous presses are written on consecutive cycles, lowest note first.
- Timestamping:
  - The prescaler counts 0 … TICK_DIV−1 and emits a tick on wrap.
  - `deltaCnt` increments on each tick and saturates at 2^TS_W−1.
- Write of an event:
  - `memWriteData = {deltaCnt, note}` and `memAddress` = current address.
  - `memWriteEnable`=1 for one cycle.
  - Then address+1 and `eventCount`+1.
  - `deltaCnt` reloads to 1 if a tick coincides with the write, otherwise to 0.
  - The second and later events of a simultaneous group therefore carry delta 0.
- Capacity:
  - Address 2^ADDR_W−1 is reserved for the end marker.
  - When `eventCount` reaches 2^ADDR_W−1, `full`=1.
  - From then on, `rise` and `pending` are discarded and no writes occur until END.
- END:
  - Writes `{deltaCnt, 3'b111}` at the current address.
  - Asserts `recordDone` for that same cycle.
  - `full` and `eventCount` hold until the next IDLE→REC.
- Reset mid-take: everything returns to reset values, and no marker is written.

## Timing
- Key press latency: `drumKeys` bit low at posedge E−1 and high at posedge E → `memWriteEnable` is high in the cycle after E (registered outputs).
- N simultaneous presses → strobes in N consecutive cycles.
- A new press during draining is merged into `pending` and served in order.
- A key held high produces one event. Release and re-press produces another.
- `recordEnable` falls at edge D with `pending`=0 → marker strobe and `recordDone` in the cycle after D+1 (one cycle in END). With pending events, the marker follows the last flushed event by one cycle.
- Throughput: at most one memory write per clk.

## Structure
- The shared macro header holds:
  - the note encodings (`DRUM_TOPLEFT`=0, `DRUM_BASS`=1, `DRUM_MIDDLE`=2, `DRUM_CYMBAL`=3, `NOTE_END`=3'b111);
  - the event word layout widths.
- The playback reader uses the same definitions.
- One sub-module: `tick_prescaler` (parameter TICK_DIV, inputs `clk`, `resetn`, `clear`, output `tick`). The FSM, `pending` mask and address logic stay in the top module.

## Test plan
- **Single press:** TICK_DIV=4, enter REC, wait 10 ticks, press F.
  - One write: addr 0, data {10, 0}.
  - `eventCount`=1.
- **Simultaneous:** press F, H and J in the same cycle.
  - Three consecutive strobes with notes 0, 2, 3 at addr n, n+1, n+2.
  - Deltas d, 0, 0.
- **Held key and pre-held key:** hold G across REC entry, then release and re-press G.
  - No event at entry.
  - Exactly one event on the re-press.
- **Stop with pending:** drop `recordEnable` in the same cycle as a 2-key press.
  - Two events, then marker 3'b111 at the next address.
  - `recordDone` pulses once.
- **Overflow:** ADDR_W=3, 9 presses.
  - 7 events at addr 0–6; `full`=1 after the 7th.
  - 8th and 9th dropped; marker at addr 7.
- **Saturation and reset:** TS_W=4, 20 ticks idle, then a press → delta 15. Then assert `resetn`=0 mid-take → all outputs 0, and no marker strobe.
